fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), bubble encoding placed in IF/ID.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
REQ-005 stall  input  1  hazard-unit hold: freezes PC and the IF/ID register.
REQ-006 flush  input  1  squash: IF/ID becomes a bubble on the next edge.
REQ-007 pc_src  input  1  redirect: next PC is taken from branch_target.
REQ-008 branch_target  input  64  redirect address from EX.
REQ-009 imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-010 imem_addr  output  64  instruction-memory address, equal to the current PC.
REQ-011 pc_out  output  64  current PC register value.
REQ-012 if_id_pc  output  64  PC of the instruction held in IF/ID.
REQ-013 if_id_instruction  output  32  instruction held in IF/ID.
REQ-014 if_id_valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
REQ-015 fetch_count  output  32  number of instructions accepted into IF/ID.
REQ-016 flush_count  output  32  number of edges on which a flush was applied.

Function
REQ-017 imem_addr and pc_out SHALL be driven directly from the PC register, with no extra cycle of latency.
REQ-018 Next-PC priority SHALL be: pc_src first, then stall, then sequential (PC+4).
- With pc_src=1, the PC SHALL load {branch_target[63:2],2'b00}, regardless of stall.
REQ-019 With pc_src=0 and stall=1, the PC SHALL hold its value.
REQ-020 In all other cases the PC SHALL load PC+4, modulo 2^64 (wrapping from 64'hFFFF_FFFF_FFFF_FFFC to 0).
REQ-021 IF/ID update priority SHALL be: flush first, then stall, then load.
- flush=1 SHALL load if_id_instruction=NOP_INSTR, if_id_pc=0 and if_id_valid=0.
- stall=1 (no flush) SHALL hold all IF/ID fields.
- Otherwise IF/ID SHALL load imem_rdata and the current PC, with if_id_valid=1.
REQ-022 An instruction fetched in cycle N SHALL appear on the if_id_* outputs after the edge ending cycle N; IF-to-ID latency is exactly 1 cycle.
REQ-023 Simultaneous flush and stall SHALL behave as flush; stall never blocks a squash.
REQ-024 fetch_count SHALL increment by 1 on each edge where IF/ID loads with valid=1, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-025 flush_count SHALL increment by 1 on each edge with flush=1, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-026 X on branch_target SHALL NOT propagate into the PC while pc_src=0.

Reset
REQ-027 While reset=0, regardless of clk:
- PC=RESET_PC
- if_id_instruction=NOP_INSTR
- if_id_pc=0
- if_id_valid=0
- fetch_count=0
- flush_count=0
REQ-028 On the first rising edge after reset deasserts, IF/ID SHALL capture the instruction at RESET_PC, and the PC SHALL advance to RESET_PC+4.
REQ-029 Reset asserted mid-operation SHALL discard any pending redirect, stall or flush, and SHALL restore all REQ-027 values immediately.

Structure
REQ-030 NOP_INSTR, XLEN=64 and ILEN=32 SHALL be defined in the shared processor package and used by all pipeline stages.
REQ-031 The IF/ID register SHALL be a sub-module if_id_reg (ports: clk, reset, stall, flush, pc_in, instr_in, and the three if_id outputs), reused by the pipeline top.
REQ-032 The PC register, next-PC mux and counters SHALL reside in fetch_stage itself.

Verification
REQ-033 Reset release; memory returns 32'h00500093 at address 0 -> after edge 1: if_id_instruction=32'h00500093, if_id_pc=0, valid=1, pc_out=4, fetch_count=1.
REQ-034 Stall held 3 cycles at PC=8 -> pc_out stays 8 and IF/ID is unchanged for 3 edges; fetch_count does not increment.
REQ-035 pc_src=1 and flush=1 for one cycle with branch_target=64'h40 -> next edge: pc_out=64'h40, valid=0, if_id_instruction=32'h00000013, flush_count=1; following edge: IF/ID holds the instruction at 64'h40 with valid=1.
REQ-036 stall=1, flush=1 and pc_src=1 together with branch_target=64'h103 -> pc_out=64'h100 and IF/ID is a bubble.
REQ-037 Force PC=64'hFFFF_FFFF_FFFF_FFFC, no stall -> next pc_out=0, and if_id_pc=64'hFFFF_FFFF_FFFF_FFFC.
REQ-038 Assert reset=0 mid-cycle during a stall -> outputs reach the REQ-027 values before the next rising edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared processor definitions used by every pipeline stage: machine word
//   width, instruction width, the bubble encoding and the fetch-alignment
//   helper used when a redirect address comes back from EX.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  // addi x0,x0,0 -- architecturally a no-op, used to fill squashed slots
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Instruction fetch is 4-byte aligned; the low two address bits are dropped
  localparam logic [XLEN-1:0] FETCH_ALIGN_MASK = ~64'h0000_0000_0000_0003;

  typedef logic [XLEN-1:0] xlen_t;
  typedef logic [ILEN-1:0] ilen_t;

  // Force a redirect address onto a word boundary
  function automatic xlen_t align_fetch(input xlen_t target);
    return target & FETCH_ALIGN_MASK;
  endfunction

endpackage : fetch_stage_pkg

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Squash (flush) wins over hold (stall); otherwise
//   the fetched word and its PC are captured and marked valid.
// Ports:
//   clk, reset (async, active-low)
//   stall, flush          hazard controls
//   pc_in, instr_in       PC and instruction word from the fetch side
//   if_id_pc, if_id_instruction, if_id_valid   registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [ILEN-1:0] BUBBLE_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [ILEN-1:0] instr_in,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instruction,
  output logic            if_id_valid
);

  // IF/ID register: flush -> bubble, stall -> hold, else capture fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_pc          <= 64'h0;
      if_id_instruction <= BUBBLE_INSTR;
      if_id_valid       <= 1'b0;
    end else if (flush) begin
      if_id_pc          <= 64'h0;
      if_id_instruction <= BUBBLE_INSTR;
      if_id_valid       <= 1'b0;
    end else if (stall) begin
      if_id_pc          <= if_id_pc;
      if_id_instruction <= if_id_instruction;
      if_id_valid       <= if_id_valid;
    end else begin
      if_id_pc          <= pc_in;
      if_id_instruction <= instr_in;
      if_id_valid       <= 1'b1;
    end
  end

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: PC register, next-PC selection, IF/ID register
//   and fetch/flush event counters.
// Ports:
//   clk, reset (async, active-low)
//   stall          hold PC and IF/ID
//   flush          squash IF/ID into a bubble
//   pc_src         redirect PC to branch_target (beats stall)
//   branch_target  redirect address from EX
//   imem_rdata     combinational instruction memory read data
//   imem_addr      instruction memory address (= PC)
//   pc_out         current PC
//   if_id_pc, if_id_instruction, if_id_valid   IF/ID contents
//   fetch_count    instructions accepted into IF/ID (wrapping)
//   flush_count    edges with flush applied (wrapping)
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter logic [ILEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instruction,
  output logic            if_id_valid,
  output logic [31:0]     fetch_count,
  output logic [31:0]     flush_count
);

  xlen_t       pc_r;
  xlen_t       next_pc_s;
  logic        fetch_accept_s;
  logic [31:0] fetch_count_r;
  logic [31:0] flush_count_r;

  // Next-PC select: redirect beats stall beats sequential. The if/else form
  // keeps an unknown branch_target out of the PC while pc_src is low.
  always_comb begin
    next_pc_s = pc_r + 64'd4;
    if (pc_src) begin
      next_pc_s = align_fetch(branch_target);
    end else if (stall) begin
      next_pc_s = pc_r;
    end else begin
      next_pc_s = pc_r + 64'd4;
    end
  end

  // IF/ID takes a real instruction only when neither squashed nor held
  always_comb begin
    fetch_accept_s = 1'b0;
    if (flush) begin
      fetch_accept_s = 1'b0;
    end else if (stall) begin
      fetch_accept_s = 1'b0;
    end else begin
      fetch_accept_s = 1'b1;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  // Event counters, both wrap naturally at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_r <= 32'h0;
      flush_count_r <= 32'h0;
    end else begin
      if (fetch_accept_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
      if (flush) begin
        flush_count_r <= flush_count_r + 32'd1;
      end else begin
        flush_count_r <= flush_count_r;
      end
    end
  end

  if_id_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .flush             (flush),
    .pc_in             (pc_r),
    .instr_in          (imem_rdata),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid)
  );

  assign imem_addr   = pc_r;
  assign pc_out      = pc_r;
  assign fetch_count = fetch_count_r;
  assign flush_count = flush_count_r;

endmodule : fetch_stage
